// File: rtl/mem_bus_ctrl.sv
// Load/store bus controller for a 2^ADDR_W x DATA_W static RAM with a shared tristate data bus.
// Optional macro MEM_BUS_TURNAROUND_EN inserts one bus-release cycle after every write.
module mem_bus_ctrl #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_chip_s,
    output logic              mem_out_en,
    output logic              mem_rw,
    inout  wire  [DATA_W-1:0] mem_data
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        TURN    = 3'd4
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] wdata_q;
    logic              drive_en;

    // Bus is driven only in WR, where mem_out_en is high, so the RAM is never driving too.
    assign mem_data = drive_en ? wdata_q : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            wr_ack     <= 1'b0;
            rsp_rdata  <= '0;
            mem_addr   <= '0;
            mem_chip_s <= 1'b1;
            mem_out_en <= 1'b1;
            mem_rw     <= 1'b1;
            wdata_q    <= '0;
            drive_en   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            wr_ack    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mem_addr   <= req_addr;
                        wdata_q    <= req_wdata;
                        req_ready  <= 1'b0;
                        mem_chip_s <= 1'b0;
                        if (req_we) begin
                            state    <= WR;
                            mem_rw   <= 1'b0;
                            drive_en <= 1'b1;
                        end else begin
                            state      <= RD_ADDR;
                            mem_out_en <= 1'b0;
                        end
                    end
                end
                RD_ADDR: begin
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    // RAM output register was loaded at the end of RD_ADDR and is on the bus now.
                    rsp_rdata  <= mem_data;
                    rsp_valid  <= 1'b1;
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    mem_chip_s <= 1'b1;
                    mem_out_en <= 1'b1;
                end
                WR: begin
                    wr_ack     <= 1'b1;
                    drive_en   <= 1'b0;
                    mem_chip_s <= 1'b1;
                    mem_rw     <= 1'b1;
`ifdef MEM_BUS_TURNAROUND_EN
                    state      <= TURN;
`else
                    state      <= IDLE;
                    req_ready  <= 1'b1;
`endif
                end
                TURN: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    mem_chip_s <= 1'b1;
                    mem_out_en <= 1'b1;
                    mem_rw     <= 1'b1;
                    drive_en   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Bus controller between the CPU pipeline's load/store stage and the 1K x 32-bit static RAM. It accepts one read or write request at a time over a valid/ready handshake. It drives the RAM's chip-select, output-enable, read/write and address lines, and owns the write side of the shared 32-bit tristate data bus. It returns read data to the pipeline with a fixed latency.

## Interface
Parameters:
- ADDR_W, 10, word address width (RAM is 2^ADDR_W x 32-bit).
- DATA_W, 32, data width of the request, response and RAM bus.

Ports:
- clk  input  1  system clock, all state on posedge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  one-cycle pulse: rsp_rdata holds read data.
- rsp_rdata  output  DATA_W  read data, held until the next read completes.
- wr_ack  output  1  one-cycle pulse: write committed to RAM.
- mem_addr  output  ADDR_W  RAM address.
- mem_chip_s  output  1  RAM chip select, active-low.
- mem_out_en  output  1  RAM output enable, 0 = RAM drives bus.
- mem_rw  output  1  1 = read, 0 = write.
- mem_data  inout  DATA_W  shared RAM data bus.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR, TURN.
- All outputs come from registers. mem_data is driven with the registered write data only in WR; in every other state it is Z.
- IDLE:
  - req_ready=1, mem_chip_s=1, mem_out_en=1, mem_rw=1.
  - A handshake (req_valid && req_ready) latches addr, we and wdata. Next state is WR if we=1, else RD_ADDR.
- RD_ADDR: mem_chip_s=0, mem_out_en=0, mem_rw=1, mem_addr=latched addr. The RAM captures its output register at the closing edge. Next state is RD_DATA.
- RD_DATA:
  - Same control values as RD_ADDR, so the RAM drives mem_data.
  - At the closing edge: rsp_rdata <= mem_data, rsp_valid pulses next cycle, next state is IDLE.
- WR:
  - mem_chip_s=0, mem_out_en=1, mem_rw=0, mem_addr=latched addr, mem_data=latched wdata.
  - The RAM writes at the closing edge. wr_ack pulses next cycle.
  - Next state is TURN if MEM_BUS_TURNAROUND_EN is defined, else IDLE.
- TURN: idle control values, bus Z, req_ready=0. Next state is IDLE.
- req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored and the request must be held by the requester.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, wr_ack=0, rsp_rdata=0, mem_addr=0, mem_chip_s=1, mem_out_en=1, mem_rw=1, mem_data=Z.
- Reset asserted mid-operation:
  - Controls return to idle values asynchronously and the bus goes Z immediately.
  - An in-flight write whose closing edge has not occurred is dropped.
  - An in-flight read produces no rsp_valid.
- The controller never drives mem_data while mem_out_en=0. Bus contention is a design error.

## Timing
- Read: handshake at edge E0; RD_ADDR in cycle E0..E1; RD_DATA in E1..E2; rsp_valid high in E2..E3. Load-to-use latency is 2 cycles after acceptance. Next accept is possible at E3 (3-cycle occupancy).
- Write: handshake at E0; WR in E0..E1; RAM commits at E1; wr_ack high in E1..E2. Next accept is at E2, or at E3 with turnaround.
- rsp_valid and wr_ack are never high in the same cycle.

## Configuration
- MEM_BUS_TURNAROUND_EN:
  - Defined: one TURN cycle after every write, so the bus is released for a full cycle before the RAM may drive it. Write occupancy is 3 cycles.
  - Undefined: WR returns directly to IDLE. Write occupancy is 2 cycles, and a read may start in the cycle right after a write.

## Test plan
- Reset then idle: hold reset low 2 cycles, release. All outputs hold their reset values and mem_data reads Z for 5 cycles.
- Write then read: write addr 0x3FF data 0x00010013, then read 0x3FF. mem_rw=0 for exactly one cycle, wr_ack one pulse, then rsp_valid exactly 2 cycles after read acceptance with rsp_rdata=0x00010013.
- Back-to-back: writes 0x001=0x000061DA and 0x008=0x00000002, then reads 0x001, 0x008, 0x002 with req_valid held high throughout. req_ready drops during each op, responses are 0x000061DA, 0x00000002 and the preloaded value, in order.
- Turnaround: write followed immediately by a read, with and without MEM_BUS_TURNAROUND_EN. The read's mem_out_en falls 2 cycles after the write acceptance edge without the macro, and 3 cycles after it with it. The controller and RAM never both drive mem_data.
- Reset mid-write: assert reset in the WR cycle before the edge. mem_chip_s rises asynchronously, no wr_ack pulses, and a later read of that address returns its old value.
- Ignored request: pulse req_valid for a write to 0x005 while in RD_DATA. The request is not accepted and the RAM at 0x005 is unchanged.
